// File: rtl/exec_pkg.sv
// Shared definitions for the execute/memory slice.
//   - ALU operation codes driven on the 3-bit op bus
//   - main-control ALUOp encodings
//   - R-type funct codes recognised by the ALU control decoder
package exec_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

endpackage

// File: rtl/exec_mem_unit_alu_ctrl_dec.sv
// ALU control decoder.
// Ports:
//   alu_op  in  2  main-control ALUOp
//   funct   in  6  instruction[5:0]
//   op      out 3  decoded ALU operation
// Unrecognised funct codes fall back to ADD.
module alu_ctrl_dec
    import exec_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] op
);

    always_comb begin
        op = OP_ADD;
        unique case (alu_op)
            ALUOP_ADD: op = OP_ADD;
            ALUOP_SUB: op = OP_SUB;
            ALUOP_OR:  op = OP_OR;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: op = OP_ADD;
                    FUNCT_SUB: op = OP_SUB;
                    FUNCT_AND: op = OP_AND;
                    FUNCT_OR:  op = OP_OR;
                    FUNCT_SLT: op = OP_SLT;
                    default:   op = OP_ADD;
                endcase
            end
            default: op = OP_ADD;
        endcase
    end

endmodule

// File: rtl/exec_mem_unit.sv
// Execute + memory slice of a single-cycle MIPS-style datapath.
// Ports:
//   clock       in   1   rising-edge clock
//   reset       in   1   synchronous active-low; clears the data memory
//   alu_op      in   2   main-control ALUOp
//   funct       in   6   instruction[5:0]
//   src_a       in   32  ALU operand A
//   src_b       in   32  ALU operand B
//   mem_read    in   1   data-memory read enable
//   mem_write   in   1   data-memory write enable
//   write_data  in   32  store data
//   op          out  3   decoded ALU operation
//   alu_result  out  32  ALU result, also the memory byte address
//   zero        out  1   alu_result == 0
//   carry_out   out  1   ALU carry (for SUB: 1 = no borrow)
//   read_data   out  32  memory read data, 0 when mem_read is low
// The memory array holds no power-up initialiser; the system is expected to
// assert reset once after power-up, which leaves every word at zero.
module exec_mem_unit
    import exec_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  alu_op,
    input  logic [5:0]  funct,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] write_data,
    output logic [2:0]  op,
    output logic [31:0] alu_result,
    output logic        zero,
    output logic        carry_out,
    output logic [31:0] read_data
);

    logic [32:0]   sum_ext;
    logic [32:0]   diff_ext;
    logic [AW-1:0] word_idx;
    logic [31:0]   mem [DEPTH];

    alu_ctrl_dec u_alu_ctrl_dec (
        .alu_op (alu_op),
        .funct  (funct),
        .op     (op)
    );

    // Subtraction as A + ~B + 1 so the carry reads as "no borrow".
    assign sum_ext  = {1'b0, src_a} + {1'b0, src_b};
    assign diff_ext = {1'b0, src_a} + {1'b0, ~src_b} + 33'd1;

    always_comb begin
        alu_result = 32'h0;
        carry_out  = 1'b0;
        case (op)
            OP_AND: alu_result = src_a & src_b;
            OP_OR:  alu_result = src_a | src_b;
            OP_ADD: {carry_out, alu_result} = sum_ext;
            OP_SUB: {carry_out, alu_result} = diff_ext;
            OP_SLT: alu_result = {31'b0, $signed(src_a) < $signed(src_b)};
            default: begin
                alu_result = 32'h0;
                carry_out  = 1'b0;
            end
        endcase
    end

    assign zero = (alu_result == 32'h0);

    // Byte address; low two bits and bits above the array size are dropped,
    // so addresses alias modulo DEPTH*4.
    assign word_idx = alu_result[AW+1:2];

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'h0;
            end
        end else if (mem_write) begin
            mem[word_idx] <= write_data;
        end
    end

    assign read_data = mem_read ? mem[word_idx] : 32'h0;

endmodule

// File: tb/tb_exec_mem_unit.sv
module tb_exec_mem_unit;

    logic        clock;
    logic        reset;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] write_data;
    logic [2:0]  op;
    logic [31:0] alu_result;
    logic        zero;
    logic        carry_out;
    logic [31:0] read_data;

    localparam int K_OP = 0, K_RES = 1, K_ZERO = 2, K_CARRY = 3, K_RD = 4;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } chk_t;

    chk_t sb[$];
    int   checks = 0;
    int   errors = 0;

    exec_mem_unit #(.DEPTH(64), .AW(6)) dut (
        .clock      (clock),
        .reset      (reset),
        .alu_op     (alu_op),
        .funct      (funct),
        .src_a      (src_a),
        .src_b      (src_b),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .write_data (write_data),
        .op         (op),
        .alu_result (alu_result),
        .zero       (zero),
        .carry_out  (carry_out),
        .read_data  (read_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] observed(int kind);
        case (kind)
            K_OP:    return {29'b0, op};
            K_RES:   return alu_result;
            K_ZERO:  return {31'b0, zero};
            K_CARRY: return {31'b0, carry_out};
            default: return read_data;
        endcase
    endfunction

    // Monitor: outputs are combinational, so they are presented every cycle;
    // everything queued since the last sample is checked mid-cycle.
    always @(negedge clock) begin
        while (sb.size() > 0) begin
            chk_t c;
            logic [31:0] act;
            c = sb.pop_front();
            act = observed(c.kind);
            checks++;
            if (act !== c.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_val(string name, int kind, logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.kind = kind;
        c.exp  = exp;
        sb.push_back(c);
    endtask

    task automatic drive_alu(logic [1:0] aop, logic [5:0] fn,
                             logic [31:0] a, logic [31:0] b);
        alu_op = aop;
        funct  = fn;
        src_a  = a;
        src_b  = b;
    endtask

    typedef struct {
        logic [1:0] aop;
        logic [5:0] fn;
        logic [2:0] exp_op;
    } dec_vec_t;

    dec_vec_t dec_tab[8] = '{
        '{2'b10, 6'h20, 3'b010},
        '{2'b10, 6'h22, 3'b110},
        '{2'b10, 6'h24, 3'b000},
        '{2'b10, 6'h25, 3'b001},
        '{2'b10, 6'h2A, 3'b111},
        '{2'b10, 6'h3F, 3'b010},
        '{2'b00, 6'h24, 3'b010},
        '{2'b01, 6'h25, 3'b110}
    };

    initial begin
        reset      = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        write_data = 32'h0;
        drive_alu(2'b00, 6'h0, 32'h0, 32'h0);
        expect_val("reset_rd_disabled", K_RD, 32'h0);
        step();
        step();
        reset = 1'b1;
        mem_read = 1'b1;
        expect_val("reset_word0_clear", K_RD, 32'h0);

        foreach (dec_tab[i]) begin
            step();
            drive_alu(dec_tab[i].aop, dec_tab[i].fn, 32'h1, 32'h2);
            expect_val($sformatf("decode_%0d", i), K_OP, {29'b0, dec_tab[i].exp_op});
        end
        mem_read = 1'b0;

        step();
        drive_alu(2'b00, 6'h0, 32'hFFFF_FFFF, 32'h1);
        expect_val("add_wrap_res",   K_RES,   32'h0);
        expect_val("add_wrap_zero",  K_ZERO,  32'h1);
        expect_val("add_wrap_carry", K_CARRY, 32'h1);

        step();
        drive_alu(2'b01, 6'h0, 32'h5, 32'h7);
        expect_val("sub_borrow_res",   K_RES,   32'hFFFF_FFFE);
        expect_val("sub_borrow_carry", K_CARRY, 32'h0);
        expect_val("sub_borrow_zero",  K_ZERO,  32'h0);

        step();
        drive_alu(2'b01, 6'h0, 32'h7, 32'h7);
        expect_val("sub_equal_res",   K_RES,   32'h0);
        expect_val("sub_equal_carry", K_CARRY, 32'h1);
        expect_val("sub_equal_zero",  K_ZERO,  32'h1);

        step();
        drive_alu(2'b10, 6'h2A, 32'hFFFF_FFFF, 32'h1);
        expect_val("slt_neg_res",   K_RES,   32'h1);
        expect_val("slt_neg_carry", K_CARRY, 32'h0);

        step();
        drive_alu(2'b10, 6'h2A, 32'h1, 32'hFFFF_FFFF);
        expect_val("slt_pos_res", K_RES, 32'h0);

        step();
        drive_alu(2'b10, 6'h24, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        expect_val("and_res",   K_RES,   32'h00F0_00F0);
        expect_val("and_carry", K_CARRY, 32'h0);

        step();
        drive_alu(2'b11, 6'h0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        expect_val("or_res",   K_RES,   32'hFFF0_FFF0);
        expect_val("or_carry", K_CARRY, 32'h0);

        // store DEADBEEF to byte address 12 (word 3)
        step();
        drive_alu(2'b00, 6'h0, 32'h8, 32'h4);
        write_data = 32'hDEAD_BEEF;
        mem_write  = 1'b1;
        mem_read   = 1'b0;
        expect_val("store_rd_gated", K_RD, 32'h0);
        step();
        mem_write = 1'b0;
        mem_read  = 1'b1;
        expect_val("load_word3", K_RD, 32'hDEAD_BEEF);
        step();
        drive_alu(2'b00, 6'h0, 32'd268, 32'h0);
        expect_val("load_alias_268", K_RD, 32'hDEAD_BEEF);
        step();
        drive_alu(2'b00, 6'h0, 32'd15, 32'h0);
        expect_val("load_lowbits_15", K_RD, 32'hDEAD_BEEF);
        step();
        drive_alu(2'b00, 6'h0, 32'd4, 32'h0);
        expect_val("load_word1_empty", K_RD, 32'h0);

        // reset clears memory and overrides a concurrent write
        step();
        drive_alu(2'b00, 6'h0, 32'd12, 32'h0);
        write_data = 32'h1234_5678;
        mem_write  = 1'b1;
        mem_read   = 1'b0;
        step();
        mem_write = 1'b0;
        mem_read  = 1'b1;
        expect_val("pre_reset_word3", K_RD, 32'h1234_5678);
        step();
        reset      = 1'b0;
        mem_write  = 1'b1;
        write_data = 32'hAAAA_5555;
        step();
        reset     = 1'b1;
        mem_write = 1'b0;
        expect_val("post_reset_word3", K_RD, 32'h0);
        step();
        mem_read = 1'b0;
        expect_val("post_reset_rd_off", K_RD, 32'h0);

        // same-cycle read/write to word 0
        step();
        drive_alu(2'b00, 6'h0, 32'h0, 32'h0);
        write_data = 32'h1;
        mem_write  = 1'b1;
        step();
        write_data = 32'h2;
        mem_read   = 1'b1;
        expect_val("rw_same_old", K_RD, 32'h1);
        step();
        mem_write = 1'b0;
        expect_val("rw_same_new", K_RD, 32'h2);

        step();
        step();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
